mem_pkt_writer: RTL and testbench
=================================

Name: mem_pkt_writer

Overview:
- Upstream driver of a data-memory write port: en, data_i[31:0], addr[13:0], we[3:0], data_o[31:0].
- Receives a packet as a byte stream with a valid/ready handshake.
- Packs bytes little-endian into 32-bit words with byte-lane enables and issues one write per word, starting at a byte address that need not be word-aligned.
- Sits between the packet builder/CRC8 stage and the packet memory.

Parameters:
- MAX_LEN, 1024, maximum bytes per packet; the stream is truncated at this count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  begin packet; sampled only in IDLE.
- base_addr_i  input  14  byte address of the first packet byte; sampled with start_i.
- byte_valid_i  input  1  byte_data_i valid.
- byte_data_i  input  8  packet byte.
- byte_last_i  input  1  final byte of packet; qualified by byte_valid_i.
- byte_ready_o  output  1  block accepts a byte.
- busy_o  output  1  not IDLE.
- done_o  output  1  one-cycle pulse when the packet is fully written.
- trunc_o  output  1  with done_o: the packet hit MAX_LEN without byte_last_i.
- byte_cnt_o  output  14  bytes accepted in the current/last packet.
- mem_en_o  output  1  memory-port en.
- mem_we_o  output  4  memory-port we; bit k enables bits [8k+7:8k].
- mem_addr_o  output  14  memory-port addr; word-aligned, bits [1:0] always 00.
- mem_data_o  output  32  memory-port data_i.

Behaviour:
- Reset: state IDLE; all outputs 0, including mem_en_o, mem_we_o, mem_addr_o, mem_data_o, byte_cnt_o, trunc_o. Internal accumulator, lane mask and pointer are cleared.
- Reset mid-packet: any partial word is discarded, no write is issued, and nothing is pending after release.
- States: IDLE -> COLLECT -> DONE -> IDLE.
- IDLE:
  - byte_ready_o = 0.
  - On start_i: latch word_ptr = base_addr_i[13:2] and lane = base_addr_i[1:0], clear byte_cnt_o and trunc_o, go to COLLECT.
- COLLECT:
  - byte_ready_o = 1 every cycle; there is no backpressure because the memory port cannot stall.
  - Accept when byte_valid_i & byte_ready_o. The byte goes to accumulator lane `lane`, mask bit `lane` is set, lane increments mod 4, and byte_cnt_o increments.
  - Word flush when the accepted byte is in lane 3, or is last, or brings byte_cnt to MAX_LEN. The flush registers are loaded on the same edge, so the write appears the cycle after the accepting cycle:
    - mem_en_o = 1.
    - mem_we_o = mask including the new byte.
    - mem_addr_o = {word_ptr, 2'b00}.
    - mem_data_o = accumulator with the new byte merged; unenabled lanes are 0.
  - After a flush: accumulator and mask clear; word_ptr increments mod 2^12, so 0x3FFC wraps to 0x0000.
  - The next flush may occur in the very next cycle, giving back-to-back writes; mem_en_o is high for exactly one cycle per write.
  - Flush on last or MAX_LEN goes to DONE. trunc_o = 1 if the reason was MAX_LEN and byte_last_i = 0.
  - start_i is ignored in COLLECT and DONE.
- DONE:
  - The final write is on the port this cycle.
  - Next edge: done_o = 1 for one cycle, state IDLE.
  - trunc_o and byte_cnt_o hold until the next start_i.
- mem_en_o = 0 implies mem_we_o = 0. Bytes with byte_valid_i = 0 are never counted. byte_last_i without byte_valid_i is ignored.
- Latency: start_i to byte_ready_o = 1 cycle. Last byte accepted at cycle N → write at N+1 → done_o at N+2.
- The block never reads memory; port data_o is unconnected.

Test Plan:
- Aligned 4-byte packet: base 0x0010, bytes 11,22,33,44 (last on 44), back-to-back. Expect one write: addr 0x0010, we 1111, data 0x44332211. done_o two cycles after 44 is accepted; byte_cnt 4; trunc 0.
- Unaligned 3 bytes: base 0x0102, bytes AA,BB,CC (last on CC).
  - Write 1: addr 0x0100, we 1100, data 0xBBAA0000.
  - Write 2: addr 0x0104, we 0001, data 0x000000CC.
- Gapped valid plus address wrap: base 0x3FFE, 6 bytes 01..06 with 1-cycle valid gaps. Writes:
  - addr 0x3FFC, we 1100, data 0x02010000.
  - addr 0x0000, we 1111, data 0x06050403.
  - Expect no extra writes during gaps.
- Truncation: MAX_LEN = 8, base 0x0000, 12 bytes without last. Expect writes at 0x0000 and 0x0004, byte_ready_o = 0 after the 8th byte, trunc_o = 1, byte_cnt 8.
- start_i re-asserted while busy: the second start and its base address are ignored; output matches the single-packet case.
- Reset mid-packet: rst_n low after 2 of 4 bytes on an aligned base.
  - Expect no write and all outputs 0 immediately.
  - A new packet after release behaves like the aligned 4-byte packet.

Source files
------------

// File: rtl/mem_pkt_writer.sv
// rtl/mem_pkt_writer.sv - packs a byte stream little-endian into 32-bit memory-port writes
module mem_pkt_writer #(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [13:0] base_addr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        trunc_o,
  output logic [13:0] byte_cnt_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [13:0] mem_addr_o,
  output logic [31:0] mem_data_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] word_ptr;
  logic [1:0]  lane;
  logic [31:0] acc;
  logic [3:0]  mask;

  logic        accept, flush, finish, hit_max;
  logic [13:0] cnt_inc;
  logic [31:0] acc_merged;
  logic [3:0]  mask_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    byte_ready_o = (state == COLLECT);
    busy_o       = (state != IDLE);
    accept       = (state == COLLECT) && byte_valid_i;
    cnt_inc      = byte_cnt_o + 14'd1;
    hit_max      = (cnt_inc == 14'(MAX_LEN));
    acc_merged   = acc | ({24'd0, byte_data_i} << {lane, 3'b000});
    mask_merged  = mask | (4'b0001 << lane);
    finish       = accept && (byte_last_i || hit_max);
    flush        = accept && ((lane == 2'd3) || byte_last_i || hit_max);
    case (state)
      IDLE:    if (start_i) state_nxt = COLLECT;
      COLLECT: if (finish)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_ptr   <= '0;
      lane       <= '0;
      acc        <= '0;
      mask       <= '0;
      byte_cnt_o <= '0;
      trunc_o    <= 1'b0;
      done_o     <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_we_o   <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      // Write strobes are single-cycle; addr/data simply hold between writes.
      mem_en_o <= 1'b0;
      mem_we_o <= '0;
      done_o   <= (state == DONE);
      if (state == IDLE && start_i) begin
        word_ptr   <= base_addr_i[13:2];
        lane       <= base_addr_i[1:0];
        byte_cnt_o <= '0;
        trunc_o    <= 1'b0;
        acc        <= '0;
        mask       <= '0;
      end
      if (accept) begin
        byte_cnt_o <= cnt_inc;
        lane       <= lane + 2'd1;
        if (flush) begin
          mem_en_o   <= 1'b1;
          mem_we_o   <= mask_merged;
          mem_addr_o <= {word_ptr, 2'b00};
          mem_data_o <= acc_merged;
          acc        <= '0;
          mask       <= '0;
          word_ptr   <= word_ptr + 12'd1;
          trunc_o    <= hit_max && !byte_last_i;
        end else begin
          acc  <= acc_merged;
          mask <= mask_merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_pkt_writer.sv
// tb/tb_mem_pkt_writer.sv - directed scoreboard bench for mem_pkt_writer
module tb_mem_pkt_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [13:0] base_addr_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_last_i = 1'b0;
  logic        byte_ready_o, busy_o, done_o, trunc_o, mem_en_o;
  logic [13:0] byte_cnt_o, mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_data_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [13:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  mem_pkt_writer #(.MAX_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_last_i(byte_last_i),
    .byte_ready_o(byte_ready_o), .busy_o(busy_o), .done_o(done_o), .trunc_o(trunc_o),
    .byte_cnt_o(byte_cnt_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write on the port must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_en_o) check("we_without_en", {28'd0, mem_we_o}, 32'd0);
      else if (exp_q.size() == 0) check("unexpected_write", {18'd0, mem_addr_o}, 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {18'd0, mem_addr_o}, {18'd0, e.addr});
        check("wr_we",   {28'd0, mem_we_o},   {28'd0, e.we});
        check("wr_data", mem_data_o, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [13:0] a, input logic [3:0] w, input logic [31:0] d);
    exp_q.push_back('{addr: a, we: w, data: d});
  endtask

  task automatic start_pkt(input logic [13:0] base);
    start_i = 1'b1;
    base_addr_i = base;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ready_after_start", {31'd0, byte_ready_o}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gap);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    byte_last_i  = last;
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Called one cycle after the last byte edge: final write on port, done next cycle.
  task automatic finish_check(input string tag, input logic [13:0] cnt, input logic trunc);
    check({tag, "_done_early"}, {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_cnt"}, {18'd0, byte_cnt_o}, {18'd0, cnt});
    check({tag, "_trunc"}, {31'd0, trunc_o}, {31'd0, trunc});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic aligned4(input string tag);
    expect_wr(14'h0010, 4'b1111, 32'h44332211);
    start_pkt(14'h0010);
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b1, 0);
    finish_check(tag, 14'd4, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", {31'd0, mem_en_o}, 32'd0);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_cnt", {18'd0, byte_cnt_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, byte_ready_o}, 32'd0);

    aligned4("aligned");

    expect_wr(14'h0100, 4'b1100, 32'hBBAA0000);
    expect_wr(14'h0104, 4'b0001, 32'h000000CC);
    start_pkt(14'h0102);
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 0);
    send(8'hCC, 1'b1, 0);
    finish_check("unaligned", 14'd3, 1'b0);

    expect_wr(14'h3FFC, 4'b1100, 32'h02010000);
    expect_wr(14'h0000, 4'b1111, 32'h06050403);
    start_pkt(14'h3FFE);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1);
    send(8'h06, 1'b1, 0);
    finish_check("wrap", 14'd6, 1'b0);

    expect_wr(14'h0000, 4'b1111, 32'h04030201);
    expect_wr(14'h0004, 4'b1111, 32'h08070605);
    start_pkt(14'h0000);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 0);
    check("trunc_ready_low", {31'd0, byte_ready_o}, 32'd0);
    byte_valid_i = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      byte_data_i = 8'(i);
      @(posedge clk); #1;
      if (i == 9) begin
        check("trunc_done", {31'd0, done_o}, 32'd1);
        check("trunc_flag", {31'd0, trunc_o}, 32'd1);
      end
    end
    byte_valid_i = 1'b0;
    check("trunc_cnt", {18'd0, byte_cnt_o}, 32'd8);
    check("trunc_drained", exp_q.size(), 32'd0);

    expect_wr(14'h0010, 4'b1111, 32'h44332211);
    start_pkt(14'h0010);
    send(8'h11, 1'b0, 0);
    start_i = 1'b1;
    base_addr_i = 14'h2000;
    send(8'h22, 1'b0, 0);
    start_i = 1'b0;
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b1, 0);
    finish_check("restart", 14'd4, 1'b0);

    start_pkt(14'h0020);
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", {18'd0, mem_addr_o}, 32'd0);
    check("mid_rst_data", mem_data_o, 32'd0);
    check("mid_rst_cnt", {18'd0, byte_cnt_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", {31'd0, busy_o}, 32'd0);
    aligned4("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
